// File: rtl/mult_sgf_seq.sv
// Sequential radix-2 shift-add significand multiplier with sign and biased exponent sum.
// Optional EARLY_ZERO_EN: a zero operand skips the iteration and goes straight to DONE with sgf_prod = 0.
module mult_sgf_seq #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      Op_MX,
  input  logic [W-1:0]      Op_MY,
  output logic              busy,
  output logic              done,
  output logic              sign_res,
  output logic [EW+1:0]     exp_sum,
  output logic              zero_flag,
  output logic [2*SW+1:0]   sgf_prod
);

  localparam int MW = SW + 1;
  localparam int PW = 2 * SW + 2;
  localparam int CW = $clog2(SW + 2);
  localparam logic [EW+1:0] BIAS     = {2'b00, 1'b0, {(EW-1){1'b1}}};
  localparam logic [CW-1:0] CNT_INIT = CW'(SW + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [MW-1:0]   a_q;
  logic [MW-1:0]   b_q;
  logic [PW-1:0]   p_q;
  logic [CW-1:0]   cnt_q;
  logic            sign_q;
  logic [EW+1:0]   exp_q;
  logic            zero_q;
  logic [PW-1:0]   prod_q;

  logic [EW-1:0]   ex_d;
  logic [EW-1:0]   ey_d;
  logic            hx_d;
  logic            hy_d;
  logic            sign_d;
  logic [EW+1:0]   exp_d;
  logic            zero_d;
  logic [MW:0]     addend_d;
  logic [MW:0]     hi_d;
  logic [PW-1:0]   p_d;

  // Operand field decode and one shift-add step on the upper accumulator half
  always_comb begin
    ex_d     = Op_MX[W-2:SW];
    ey_d     = Op_MY[W-2:SW];
    hx_d     = |ex_d;
    hy_d     = |ey_d;
    sign_d   = Op_MX[W-1] ^ Op_MY[W-1];
    exp_d    = {2'b00, ex_d} + {2'b00, ey_d} - BIAS;
    zero_d   = ~hx_d | ~hy_d;
    addend_d = b_q[0] ? {1'b0, a_q} : {(MW+1){1'b0}};
    hi_d     = {1'b0, p_q[PW-1:SW+1]} + addend_d;
    p_d      = {hi_d, p_q[SW:1]};
  end

  // Control FSM and all datapath/result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= {hx_d, Op_MX[SW-1:0]};
            b_q    <= {hy_d, Op_MY[SW-1:0]};
            p_q    <= '0;
            cnt_q  <= CNT_INIT;
            sign_q <= sign_d;
            exp_q  <= exp_d;
            zero_q <= zero_d;
`ifdef EARLY_ZERO_EN
            if (zero_d) begin
              prod_q  <= '0;
              state_q <= DONE;
            end else begin
              state_q <= MULT;
            end
`else
            state_q <= MULT;
`endif
          end
        end
        MULT: begin
          p_q   <= p_d;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - CNT_ONE;
          // Last iteration: publish the finished product as the state leaves MULT
          if (cnt_q == CNT_ONE) begin
            prod_q  <= p_d;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sign_res  = sign_q;
  assign exp_sum   = exp_q;
  assign zero_flag = zero_q;
  assign sgf_prod  = prod_q;

endmodule

// File: tb/tb_mult_sgf_seq.sv
// Scoreboard bench for mult_sgf_seq (single precision): driver queues expected results, monitor checks on done.
module tb_mult_sgf_seq;

  localparam int W  = 32;
  localparam int EW = 8;
  localparam int SW = 23;
  localparam int PW = 2 * SW + 2;
  localparam int LAT = SW + 1;
`ifdef EARLY_ZERO_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = SW + 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    op_x = '0;
  logic [W-1:0]    op_y = '0;
  logic            busy;
  logic            done;
  logic            sign_res;
  logic [EW+1:0]   exp_sum;
  logic            zero_flag;
  logic [PW-1:0]   sgf_prod;

  mult_sgf_seq #(.W(W), .EW(EW), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Op_MX     (op_x),
    .Op_MY     (op_y),
    .busy      (busy),
    .done      (done),
    .sign_res  (sign_res),
    .exp_sum   (exp_sum),
    .zero_flag (zero_flag),
    .sgf_prod  (sgf_prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic [EW+1:0] e;
    logic          z;
    logic [PW-1:0] p;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: counts MULT cycles, checks every done pulse against the queue head
  initial begin : monitor
    int   mult_cnt;
    bit   prev_done;
    exp_t e;
    mult_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("busy_after_done", 64'(busy), 64'(0));
      prev_done = done;
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done pulse with empty scoreboard, sgf_prod=0x%0h", sgf_prod);
        end else begin
          e = sb.pop_front();
          chk("sign_res",  64'(sign_res),  64'(e.s));
          chk("exp_sum",   64'(exp_sum),   64'(e.e));
          chk("zero_flag", 64'(zero_flag), 64'(e.z));
          chk("sgf_prod",  64'(sgf_prod),  64'(e.p));
          chk("latency",   64'(mult_cnt),  64'(e.lat));
        end
        mult_cnt = 0;
      end else if (busy) begin
        mult_cnt++;
      end else begin
        mult_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [EW+1:0] e, input logic z, input logic [PW-1:0] p, input int lat);
    exp_t t;
    t.s = s; t.e = e; t.z = z; t.p = p; t.lat = lat;
    @(negedge clk);
    op_x  = x;
    op_y  = y;
    start = 1'b1;
    sb.push_back(t);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending, busy=%0b", sb.size(), busy);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy),      64'(0));
    chk({tag, "_done"}, 64'(done),      64'(0));
    chk({tag, "_sign"}, 64'(sign_res),  64'(0));
    chk({tag, "_exp"},  64'(exp_sum),   64'(0));
    chk({tag, "_zero"}, 64'(zero_flag), 64'(0));
    chk({tag, "_prod"}, 64'(sgf_prod),  64'(0));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    issue(32'h3F800000, 32'h3F800000, 1'b0, 10'h07F, 1'b0, 48'h4000_0000_0000, LAT);
    wait_idle();
    issue(32'hBFC00000, 32'h40000000, 1'b1, 10'h080, 1'b0, 48'h6000_0000_0000, LAT);
    wait_idle();
    issue(32'h00000000, 32'h3F800000, 1'b0, 10'h000, 1'b1, 48'h0, ZLAT);
    wait_idle();
    issue(32'h00800000, 32'h00800000, 1'b0, 10'h383, 1'b0, 48'h4000_0000_0000, LAT);
    wait_idle();
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 10'h17D, 1'b0, 48'hFFFF_FE00_0001, LAT);
    wait_idle();

    // Results must hold while idle
    repeat (3) @(negedge clk);
    chk("hold_prod", 64'(sgf_prod), 64'(48'hFFFF_FE00_0001));
    chk("hold_exp",  64'(exp_sum),  64'(10'h17D));

    // Second start during MULT must be ignored
    issue(32'hBFC00000, 32'h40000000, 1'b1, 10'h080, 1'b0, 48'h6000_0000_0000, LAT);
    repeat (3) @(posedge clk);
    @(negedge clk);
    op_x  = 32'h40400000;
    op_y  = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation
    issue(32'h3F800000, 32'h3F800000, 1'b0, 10'h07F, 1'b0, 48'h4000_0000_0000, LAT);
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;

    issue(32'h40400000, 32'h40400000, 1'b0, 10'h081, 1'b0, 48'h9000_0000_0000, LAT);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
